// File: rtl/vx_gpr_wb_arbiter.sv
// vx_gpr_wb_arbiter: round-robin writeback arbiter feeding the GPR write port
// through a one-entry output register. Null writebacks (rd==0 or tmask==0)
// are accepted but never forwarded. perf_stalls counts cycles where some
// requester is valid but nothing is granted.
// Optional build macro: GPR_WB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module vx_gpr_wb_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 req_valid,
  input  logic [NUM_REQS*NW_BITS-1:0]         req_wid,
  input  logic [NUM_REQS*NR_BITS-1:0]         req_rd,
  input  logic [NUM_REQS*NUM_THREADS-1:0]     req_tmask,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0]  req_data,
  output logic [NUM_REQS-1:0]                 req_ready,
  output logic                                wb_valid,
  output logic [NW_BITS-1:0]                  wb_wid,
  output logic [NR_BITS-1:0]                  wb_rd,
  output logic [NUM_THREADS-1:0]              wb_tmask,
  output logic [NUM_THREADS*32-1:0]           wb_data,
  input  logic                                wb_ready,
  output logic [31:0]                         perf_stalls
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQS);
  localparam int unsigned DATA_W = NUM_THREADS * 32;

  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [NR_BITS-1:0]     rd;
    logic [NUM_THREADS-1:0] tmask;
    logic [DATA_W-1:0]      data;
  } wb_entry_t;

  logic             wb_valid_q, wb_valid_d;
  wb_entry_t        wb_entry_q, wb_entry_d;
  logic [31:0]      perf_stalls_q, perf_stalls_d;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W:0]   cand_sum;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic             grant_fire;
  logic             out_free;
  wb_entry_t        sel_entry;
  logic             sel_null;

`ifdef GPR_WB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign rr_ptr = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  assign rr_ptr = rr_ptr_q;

  // Pointer moves one past the winner on every grant, null or not.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_fire) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQS - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand_sum >= (PTR_W + 1)'(NUM_REQS)) begin
        cand_sum = cand_sum - (PTR_W + 1)'(NUM_REQS);
      end
      if (!grant_found && req_valid[cand_sum[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[PTR_W-1:0];
      end
    end
  end

  // Grant qualification and one-hot accept; a full, stalled output blocks everyone.
  always_comb begin
    out_free   = !wb_valid_q || wb_ready;
    grant_fire = grant_found && out_free && !reset;
    req_ready  = '0;
    if (grant_fire) req_ready[grant_idx] = 1'b1;
  end

  // Winner's payload and null classification.
  always_comb begin
    sel_entry.wid   = req_wid[grant_idx*NW_BITS +: NW_BITS];
    sel_entry.rd    = req_rd[grant_idx*NR_BITS +: NR_BITS];
    sel_entry.tmask = req_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
    sel_entry.data  = req_data[grant_idx*DATA_W +: DATA_W];
    sel_null        = (sel_entry.rd == '0) || (sel_entry.tmask == '0);
  end

  // Output register next state and stall counter.
  always_comb begin
    wb_valid_d    = wb_valid_q;
    wb_entry_d    = wb_entry_q;
    perf_stalls_d = perf_stalls_q;
    if (out_free) begin
      wb_valid_d = 1'b0;
      if (grant_fire && !sel_null) begin
        wb_valid_d = 1'b1;
        wb_entry_d = sel_entry;
      end
    end
    if ((|req_valid) && !grant_fire) begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // Output register and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q    <= 1'b0;
      wb_entry_q    <= '0;
      perf_stalls_q <= '0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_entry_q    <= wb_entry_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_wid      = wb_entry_q.wid;
  assign wb_rd       = wb_entry_q.rd;
  assign wb_tmask    = wb_entry_q.tmask;
  assign wb_data     = wb_entry_q.data;
  assign perf_stalls = perf_stalls_q;

endmodule

// File: tb/tb_vx_gpr_wb_arbiter.sv
// Testbench for vx_gpr_wb_arbiter: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the arbiter.
module tb_vx_gpr_wb_arbiter;

  localparam int N  = 4;
  localparam int T  = 4;
  localparam int NW = 2;
  localparam int NR = 5;
  localparam int DW = T * 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*NW-1:0]   req_wid;
  logic [N*NR-1:0]   req_rd;
  logic [N*T-1:0]    req_tmask;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              wb_valid;
  logic [NW-1:0]     wb_wid;
  logic [NR-1:0]     wb_rd;
  logic [T-1:0]      wb_tmask;
  logic [DW-1:0]     wb_data;
  logic              wb_ready;
  logic [31:0]       perf_stalls;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_ptr = 0;
  bit          m_valid = 1'b0;
  bit [NW-1:0] m_wid;
  bit [NR-1:0] m_rd;
  bit [T-1:0]  m_tmask;
  bit [DW-1:0] m_data;
  bit [31:0]   m_stalls = '0;

  vx_gpr_wb_arbiter #(.NUM_REQS(N), .NUM_THREADS(T), .NW_BITS(NW), .NR_BITS(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wid(req_wid), .req_rd(req_rd),
    .req_tmask(req_tmask), .req_data(req_data), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd),
    .wb_tmask(wb_tmask), .wb_data(wb_data), .wb_ready(wb_ready),
    .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  // Expected winner this cycle from the model, -1 if none.
  function automatic int exp_grant();
    if (reset) return -1;
    if (m_valid && !wb_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] ready_of(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance the model by one clock using the inputs of the cycle just ended.
  task automatic commit(input int g);
    if (reset) begin
      m_ptr = 0; m_valid = 1'b0; m_stalls = '0;
      return;
    end
    if ((|req_valid) && g < 0) m_stalls = m_stalls + 32'd1;
    if (!m_valid || wb_ready) begin
      m_valid = 1'b0;
      if (g >= 0 && req_rd[g*NR +: NR] != '0 && req_tmask[g*T +: T] != '0) begin
        m_valid = 1'b1;
        m_wid   = req_wid[g*NW +: NW];
        m_rd    = req_rd[g*NR +: NR];
        m_tmask = req_tmask[g*T +: T];
        m_data  = req_data[g*DW +: DW];
      end
    end
`ifdef GPR_WB_FIXED_PRIO_EN
    m_ptr = 0;
`else
    if (g >= 0) m_ptr = (g + 1) % N;
`endif
  endtask

  task automatic advance(input int g);
    @(posedge clk);
    commit(g);
    #1;
  endtask

  task automatic set_req(input int i, input logic [NW-1:0] w, input logic [NR-1:0] r,
                         input logic [T-1:0] tm, input logic [DW-1:0] d);
    req_wid[i*NW +: NW] = w;
    req_rd[i*NR +: NR]  = r;
    req_tmask[i*T +: T] = tm;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    int g;
    reset = 1'b1; wb_ready = 1'b1; req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, NW'(i), 5'd5, 4'hF, {4{$urandom()}});
    for (int c = 0; c < 2; c++) begin
      advance(-1);
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready c%0d got %b exp 0", c, req_ready); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid c%0d got %b exp 0", c, wb_valid); end
      checks++; if (perf_stalls !== 32'd0) begin errors++; $display("FAIL reset_stalls c%0d got %0d exp 0", c, perf_stalls); end
    end
    reset = 1'b0;
    #1;
    g = exp_grant();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
    advance(g);
  endtask

  task automatic test_round_robin();
    int g; int p0;
    req_valid = '1; wb_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, NW'(i), 5'd5, 4'hF, {$urandom(), $urandom(), $urandom(), $urandom()});
    #1;
    p0 = m_ptr;
    for (int c = 0; c < 5; c++) begin
      g = exp_grant();
      checks++; if (req_ready !== ready_of(g)) begin errors++; $display("FAIL rr_ready c%0d got %b exp %b", c, req_ready, ready_of(g)); end
`ifndef GPR_WB_FIXED_PRIO_EN
      checks++; if (req_ready !== ready_of((p0 + c) % N)) begin errors++; $display("FAIL rr_order c%0d got %b exp %b", c, req_ready, ready_of((p0 + c) % N)); end
`endif
      checks++; if (wb_valid !== m_valid) begin errors++; $display("FAIL rr_wb_valid c%0d got %b exp %b", c, wb_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if ({wb_wid, wb_rd, wb_tmask, wb_data} !== {m_wid, m_rd, m_tmask, m_data}) begin
          errors++; $display("FAIL rr_payload c%0d got wid %0d rd %0d data %h exp wid %0d rd %0d data %h", c, wb_wid, wb_rd, wb_data, m_wid, m_rd, m_data);
        end
      end
      advance(g);
    end
    req_valid = '0;
    advance(exp_grant());
  endtask

  task automatic test_back_pressure();
    int g; bit [31:0] s0;
    req_valid = 4'b0100; wb_ready = 1'b1;
    set_req(2, 2'd2, 5'd7, 4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    #1;
    g = exp_grant();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_load got %b exp 0100", req_ready); end
    advance(g);
    wb_ready = 1'b0;
    s0 = m_stalls;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c%0d got %b exp 0000", c, req_ready); end
      checks++;
      if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
        errors++; $display("FAIL bp_hold c%0d got v %b rd %0d data %h", c, wb_valid, wb_rd, wb_data);
      end
      advance(exp_grant());
    end
    checks++; if (perf_stalls !== s0 + 32'd3) begin errors++; $display("FAIL bp_stalls got %0d exp %0d", perf_stalls, s0 + 32'd3); end
    checks++; if (perf_stalls !== m_stalls) begin errors++; $display("FAIL bp_stalls_model got %0d exp %0d", perf_stalls, m_stalls); end
    wb_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_drain_refill got %b exp 0100", req_ready); end
    advance(exp_grant());
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble got %b exp 1", wb_valid); end
    req_valid = '0;
    advance(exp_grant());
  endtask

  task automatic test_null_wb();
    int g;
    wb_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req_valid = 4'b0010;
      if (c == 0) set_req(1, 2'd1, 5'd0, 4'hF, {4{32'h1111_0000}});
      else        set_req(1, 2'd1, 5'd3, 4'h0, {4{32'h2222_0000}});
      #1;
      g = exp_grant();
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL null_ready c%0d got %b exp 0010", c, req_ready); end
      advance(g);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL null_wb_valid c%0d got %b exp 0", c, wb_valid); end
    end
    req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, NW'(i), 5'd4, 4'h3, {4{$urandom()}});
    #1;
    g = exp_grant();
`ifndef GPR_WB_FIXED_PRIO_EN
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL null_ptr_advance got %b exp 0100", req_ready); end
`endif
    checks++; if (req_ready !== ready_of(g)) begin errors++; $display("FAIL null_ptr_model got %b exp %b", req_ready, ready_of(g)); end
    advance(g);
    req_valid = '0;
    advance(exp_grant());
  endtask

  task automatic test_mixed();
    int g;
    wb_ready = 1'b1;
    req_valid = 4'b1000;
    set_req(3, 2'd3, 5'd0, 4'hF, '0);
    #1;
    advance(exp_grant());
    req_valid = 4'b1001;
    set_req(0, 2'd0, 5'd0, 4'hF, {4{32'hDEAD_0000}});
    set_req(3, 2'd3, 5'd9, 4'h5, {4{32'h9999_0009}});
    #1;
    g = exp_grant();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mixed_c1 got %b exp 0001", req_ready); end
    advance(g);
    req_valid = 4'b1000;
    #1;
    g = exp_grant();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mixed_c2 got %b exp 1000", req_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mixed_null_out got %b exp 0", wb_valid); end
    advance(g);
    req_valid = '0;
    #1;
    checks++; if ({wb_valid, wb_rd, wb_wid} !== {1'b1, 5'd9, 2'd3}) begin
      errors++; $display("FAIL mixed_c3 got v %b rd %0d wid %0d exp v 1 rd 9 wid 3", wb_valid, wb_rd, wb_wid);
    end
    advance(exp_grant());
  endtask

  task automatic test_random();
    int g; logic [N-1:0] held;
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      reset    = (c == 200);
      wb_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = exp_grant();
      checks++; if (req_ready !== ready_of(g)) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, req_ready, ready_of(g)); end
      checks++; if (wb_valid !== m_valid) begin errors++; $display("FAIL rand_wb_valid c%0d got %b exp %b", c, wb_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if ({wb_wid, wb_rd, wb_tmask, wb_data} !== {m_wid, m_rd, m_tmask, m_data}) begin
          errors++; $display("FAIL rand_payload c%0d got rd %0d tm %h exp rd %0d tm %h", c, wb_rd, wb_tmask, m_rd, m_tmask);
        end
      end
      checks++; if (perf_stalls !== m_stalls) begin errors++; $display("FAIL rand_stalls c%0d got %0d exp %0d", c, perf_stalls, m_stalls); end
      held = req_valid & ~ready_of(g);
      advance(g);
      for (int i = 0; i < N; i++) begin
        if (!held[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          set_req(i, NW'($urandom()), ($urandom_range(0, 7) == 0) ? 5'd0 : NR'($urandom_range(1, 31)),
                  ($urandom_range(0, 7) == 0) ? 4'h0 : T'($urandom()),
                  {$urandom(), $urandom(), $urandom(), $urandom()});
        end
      end
    end
    reset = 1'b0;
    req_valid = '0;
    advance(exp_grant());
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_wid = '0; req_rd = '0;
    req_tmask = '0; req_data = '0; wb_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_null_wb();
    test_mixed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
